// File: rtl/memory_stage.sv
// Pipeline MEM stage: drives the data-memory request/grant/response handshake
// for loads and stores, aligns and extends load data, and fills the MEM/WB
// register. Upstream is stalled while a memory transaction has not retired.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exValid,
  input  logic [31:0] exAluResult,
  input  logic [31:0] exRamData,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic [2:0]  exFunct3,
  input  logic        exRegWrite,
  input  logic        exMemToReg,
  input  logic [4:0]  exRd,
  output logic        memStall,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [31:0] dWdata,
  output logic [3:0]  dBe,
  input  logic        dGnt,
  input  logic        dRvalid,
  input  logic [31:0] dRdata,
  output logic        wbValid,
  output logic        wbRegWrite,
  output logic        wbMemToReg,
  output logic [4:0]  wbRd,
  output logic [31:0] wbAluResult,
  output logic [31:0] wbLoadData,
  output logic        misalignFault,
  output logic [31:0] faultAddr
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t      state, stateNext;
  logic [1:0]  off;
  logic        active, memOp, sizeFault, faultNow, retire;
  logic [3:0]  beRaw;
  logic [31:0] shifted, loadData;

  assign off   = exAluResult[1:0];
  assign dAddr = {exAluResult[31:2], 2'b00};

  // Size/alignment legality of the current access
  always_comb begin
    sizeFault = 1'b0;
    case (exFunct3)
      3'b000, 3'b100: sizeFault = 1'b0;
      3'b001, 3'b101: sizeFault = off[0];
      3'b010:         sizeFault = (off != 2'b00);
      default:        sizeFault = 1'b1;
    endcase
  end

  // Store lane replication and byte enables
  always_comb begin
    beRaw  = 4'b1111;
    dWdata = exRamData;
    case (exFunct3[1:0])
      2'b00: begin
        beRaw  = 4'b0001 << off;
        dWdata = {4{exRamData[7:0]}};
      end
      2'b01: begin
        beRaw  = 4'b0011 << off;
        dWdata = {2{exRamData[15:0]}};
      end
      default: begin
        beRaw  = 4'b1111;
        dWdata = exRamData;
      end
    endcase
  end

  // Load byte/half selection and sign/zero extension
  always_comb begin
    shifted  = dRdata >> {off, 3'b000};
    loadData = dRdata;
    case (exFunct3)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadData = {24'h0, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  loadData = {16'h0, shifted[15:0]};
      default: loadData = dRdata;
    endcase
  end

  // Next-state, request, stall and retire decode; everything quiet during reset
  always_comb begin
    stateNext = state;
    dReq      = 1'b0;
    memStall  = 1'b0;
    retire    = 1'b0;
    faultNow  = 1'b0;
    active    = exValid & ~rst;
    memOp     = active & (exMemRead | exMemWrite);
    if (!rst) begin
      case (state)
        IDLE: begin
          if (active) begin
            if (!memOp) begin
              retire = 1'b1;
            end else if (sizeFault) begin
              faultNow = 1'b1;
            end else begin
              dReq = 1'b1;
              if (exMemWrite && dGnt) begin
                retire = 1'b1;
              end else begin
                memStall  = 1'b1;
                stateNext = (exMemRead && dGnt) ? WAIT_RVALID : WAIT_GNT;
              end
            end
          end
        end
        WAIT_GNT: begin
          dReq = 1'b1;
          if (dGnt && exMemWrite) begin
            retire    = 1'b1;
            stateNext = IDLE;
          end else begin
            memStall = 1'b1;
            if (dGnt) stateNext = WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (dRvalid) begin
            retire    = 1'b1;
            stateNext = IDLE;
          end else begin
            memStall = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
    dWe = dReq & exMemWrite;
    dBe = dReq ? beRaw : 4'b0000;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // MEM/WB register and fault capture; non-retiring cycles load a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid       <= 1'b0;
      wbRegWrite    <= 1'b0;
      wbMemToReg    <= 1'b0;
      wbRd          <= '0;
      wbAluResult   <= '0;
      wbLoadData    <= '0;
      misalignFault <= 1'b0;
      faultAddr     <= '0;
    end else begin
      misalignFault <= faultNow;
      if (faultNow) faultAddr <= exAluResult;
      if (retire) begin
        wbValid     <= 1'b1;
        wbRegWrite  <= exRegWrite;
        wbMemToReg  <= exMemToReg;
        wbRd        <= exRd;
        wbAluResult <= exAluResult;
        wbLoadData  <= (state == WAIT_RVALID) ? loadData : '0;
      end else begin
        wbValid     <= 1'b0;
        wbRegWrite  <= 1'b0;
        wbMemToReg  <= 1'b0;
        wbRd        <= '0;
        wbAluResult <= '0;
        wbLoadData  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table of transactions driven through
// a bus responder, MEM/WB results checked by a scoreboard, plus hand-written
// reset and fault sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid, exMemRead, exMemWrite, exRegWrite, exMemToReg;
  logic [31:0] exAluResult, exRamData;
  logic [2:0]  exFunct3;
  logic [4:0]  exRd;
  logic        memStall, dReq, dWe, dGnt, dRvalid;
  logic [31:0] dAddr, dWdata, dRdata;
  logic [3:0]  dBe;
  logic        wbValid, wbRegWrite, wbMemToReg, misalignFault;
  logic [4:0]  wbRd;
  logic [31:0] wbAluResult, wbLoadData, faultAddr;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .exValid(exValid), .exAluResult(exAluResult), .exRamData(exRamData),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exFunct3(exFunct3),
    .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exRd(exRd),
    .memStall(memStall), .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dWdata(dWdata), .dBe(dBe), .dGnt(dGnt), .dRvalid(dRvalid),
    .dRdata(dRdata), .wbValid(wbValid), .wbRegWrite(wbRegWrite),
    .wbMemToReg(wbMemToReg), .wbRd(wbRd), .wbAluResult(wbAluResult),
    .wbLoadData(wbLoadData), .misalignFault(misalignFault),
    .faultAddr(faultAddr)
  );

  // kind: 0 ALU, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          gntWait;
    int          rvWait;
    logic [31:0] rdata;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
    logic        expFault;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] load;
    logic        regWrite;
    logic        memToReg;
  } wb_t;

  wb_t sbq[$];
  int  nCmp = 0;
  int  nFail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every MEM/WB valid must match the oldest expected retire
  always @(posedge clk) begin
    wb_t e;
    #1;
    if (wbValid === 1'b1) begin
      if (sbq.size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL wb_unexpected: got wbValid=1 rd=%0d expected no retire at %0t", wbRd, $time);
      end else begin
        e = sbq.pop_front();
        chk("wb_rd", 32'(wbRd), 32'(e.rd));
        chk("wb_alu", wbAluResult, e.alu);
        chk("wb_load", wbLoadData, e.load);
        chk1("wb_regWrite", wbRegWrite, e.regWrite);
        chk1("wb_memToReg", wbMemToReg, e.memToReg);
      end
    end
  end

  function automatic vec_t mk(input int kind, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] f3, input logic [4:0] rd, input int g, input int r,
                              input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] load, input logic fault);
    vec_t v;
    v.kind = kind; v.addr = addr; v.data = data; v.f3 = f3; v.rd = rd;
    v.gntWait = g; v.rvWait = r; v.rdata = rdata; v.expBe = be;
    v.expWdata = wdata; v.expLoad = load; v.expFault = fault;
    return v;
  endfunction

  task automatic idleCycle();
    @(negedge clk);
    exValid = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0;
    dGnt = 1'b0; dRvalid = 1'b0;
    #1;
    chk1("idle_stall", memStall, 1'b0);
    chk1("idle_dReq", dReq, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic runOp(input vec_t v);
    bit  isLoad, isStore, isMem, rPhase, done, reqExp, stallExp;
    int  gLeft, rLeft, cyc;
    wb_t e;
    isLoad = (v.kind == 1); isStore = (v.kind == 2); isMem = isLoad || isStore;
    gLeft = v.gntWait; rLeft = 0; rPhase = 0; done = 0; cyc = 0;
    @(negedge clk);
    exValid = 1'b1; exAluResult = v.addr; exRamData = v.data;
    exMemRead = isLoad; exMemWrite = isStore; exFunct3 = v.f3;
    exRegWrite = !isStore; exMemToReg = isLoad; exRd = v.rd;
    if (!v.expFault) begin
      e.rd = v.rd; e.alu = v.addr; e.load = v.expLoad;
      e.regWrite = !isStore; e.memToReg = isLoad;
      sbq.push_back(e);
    end
    while (!done && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      reqExp = 0; stallExp = 0;
      dGnt = 1'b0; dRvalid = 1'b0; dRdata = 32'h5A5A_5A5A;
      if (isMem && !v.expFault) begin
        if (!rPhase) begin
          dGnt = (gLeft == 0);
          reqExp = 1;
          stallExp = !(isStore && dGnt);
        end else begin
          dRvalid = (rLeft == 0);
          if (dRvalid) dRdata = v.rdata;
          stallExp = !dRvalid;
        end
      end
      #1;
      chk1("memStall", memStall, stallExp);
      chk1("dReq", dReq, reqExp);
      if (reqExp) begin
        chk("dAddr", dAddr, {v.addr[31:2], 2'b00});
        chk1("dWe", dWe, isStore);
        if (isStore) begin
          chk("dBe", 32'(dBe), 32'(v.expBe));
          chk("dWdata", dWdata, v.expWdata);
        end
      end
      if (!isMem || v.expFault) done = 1;
      else if (!rPhase) begin
        if (dGnt) begin
          if (isStore) done = 1;
          else begin rPhase = 1; rLeft = v.rvWait; end
        end else gLeft--;
      end else begin
        if (dRvalid) done = 1;
        else rLeft--;
      end
      @(posedge clk); #1;
      if (!done) chk1("wbValid_bubble", wbValid, 1'b0);
      else if (v.expFault) begin
        chk1("fault_wbValid", wbValid, 1'b0);
        chk1("fault_pulse", misalignFault, 1'b1);
        chk("fault_addr", faultAddr, v.addr);
      end else begin
        chk1("wbValid_retire", wbValid, 1'b1);
        chk1("no_fault", misalignFault, 1'b0);
      end
      cyc++;
    end
    if (!done) begin
      nCmp++; nFail++;
      $display("FAIL timeout: got no retire in %0d cycles expected retire", cyc);
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = mk(0, 32'h0000_1234, 32'h0,          3'b000, 5'd5,  0, 0, 32'h0,          4'b0000, 32'h0,          32'h0,          1'b0);
    vecs[1]  = mk(2, 32'h0000_0103, 32'hAABB_CCDD, 3'b000, 5'd0,  0, 0, 32'h0,          4'b1000, 32'hDDDD_DDDD, 32'h0,          1'b0);
    vecs[2]  = mk(1, 32'h0000_0102, 32'h0,          3'b000, 5'd7,  0, 1, 32'h0080_0000, 4'b0000, 32'h0,          32'hFFFF_FF80, 1'b0);
    vecs[3]  = mk(1, 32'h0000_0102, 32'h0,          3'b100, 5'd8,  0, 1, 32'h0080_0000, 4'b0000, 32'h0,          32'h0000_0080, 1'b0);
    vecs[4]  = mk(2, 32'h0000_0200, 32'h1234_5678, 3'b010, 5'd0,  3, 0, 32'h0,          4'b1111, 32'h1234_5678, 32'h0,          1'b0);
    vecs[5]  = mk(1, 32'h0000_0202, 32'h0,          3'b010, 5'd9,  0, 0, 32'h0,          4'b0000, 32'h0,          32'h0,          1'b1);
    vecs[6]  = mk(1, 32'h0000_0202, 32'h0,          3'b001, 5'd10, 1, 0, 32'h8001_0000, 4'b0000, 32'h0,          32'hFFFF_8001, 1'b0);
    vecs[7]  = mk(1, 32'h0000_0202, 32'h0,          3'b101, 5'd11, 0, 0, 32'h8001_0000, 4'b0000, 32'h0,          32'h0000_8001, 1'b0);
    vecs[8]  = mk(2, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 5'd0,  0, 0, 32'h0,          4'b1100, 32'hABCD_ABCD, 32'h0,          1'b0);
    vecs[9]  = mk(1, 32'h0000_0104, 32'h0,          3'b010, 5'd12, 2, 2, 32'hDEAD_BEEF, 4'b0000, 32'h0,          32'hDEAD_BEEF, 1'b0);
    vecs[10] = mk(1, 32'h0000_0000, 32'h0,          3'b011, 5'd13, 0, 0, 32'h0,          4'b0000, 32'h0,          32'h0,          1'b1);
    vecs[11] = mk(2, 32'h0000_0101, 32'hFFFF_FFFF, 3'b001, 5'd0,  0, 0, 32'h0,          4'b0000, 32'h0,          32'h0,          1'b1);
    vecs[12] = mk(1, 32'h0000_0101, 32'h0,          3'b000, 5'd14, 0, 0, 32'h0000_7F00, 4'b0000, 32'h0,          32'h0000_007F, 1'b0);
    vecs[13] = mk(2, 32'h0000_0100, 32'h0000_0055, 3'b000, 5'd0,  1, 0, 32'h0,          4'b0001, 32'h5555_5555, 32'h0,          1'b0);

    rst = 1'b1; exValid = 1'b0; exAluResult = '0; exRamData = '0;
    exMemRead = 1'b0; exMemWrite = 1'b0; exFunct3 = 3'b000;
    exRegWrite = 1'b0; exMemToReg = 1'b0; exRd = '0;
    dGnt = 1'b0; dRvalid = 1'b0; dRdata = '0;

    // Reset state, with a live load presented while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    exValid = 1'b1; exMemRead = 1'b1; exFunct3 = 3'b010; exAluResult = 32'h40;
    #1;
    chk1("rst_dReq", dReq, 1'b0);
    chk1("rst_dWe", dWe, 1'b0);
    chk("rst_dBe", 32'(dBe), 32'h0);
    chk1("rst_stall", memStall, 1'b0);
    @(posedge clk); #1;
    chk1("rst_wbValid", wbValid, 1'b0);
    chk1("rst_wbRegWrite", wbRegWrite, 1'b0);
    chk1("rst_wbMemToReg", wbMemToReg, 1'b0);
    chk("rst_wbRd", 32'(wbRd), 32'h0);
    chk("rst_wbAlu", wbAluResult, 32'h0);
    chk("rst_wbLoad", wbLoadData, 32'h0);
    chk1("rst_fault", misalignFault, 1'b0);
    chk("rst_faultAddr", faultAddr, 32'h0);
    @(negedge clk);
    rst = 1'b0; exValid = 1'b0; exMemRead = 1'b0;
    idleCycle();

    // Table of transactions, issued back to back
    for (int i = 0; i < 14; i++) begin
      runOp(vecs[i]);
      if (vecs[i].expFault) begin
        idleCycle();
        chk1("fault_one_cycle", misalignFault, 1'b0);
        chk("fault_addr_held", faultAddr, vecs[i].addr);
      end
    end

    // Stray response while idle must be ignored
    @(negedge clk);
    exValid = 1'b0; dGnt = 1'b0; dRvalid = 1'b1; dRdata = 32'h1111_2222;
    #1;
    chk1("stray_rvalid_stall", memStall, 1'b0);
    @(posedge clk); #1;
    chk1("stray_rvalid_wb", wbValid, 1'b0);

    // Reset while waiting for read data; the late response is dropped
    @(negedge clk);
    dRvalid = 1'b0;
    exValid = 1'b1; exMemRead = 1'b1; exMemWrite = 1'b0; exFunct3 = 3'b010;
    exAluResult = 32'h300; exRd = 5'd3; exRegWrite = 1'b1; exMemToReg = 1'b1;
    dGnt = 1'b1;
    #1;
    chk1("rstmid_req", dReq, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    dGnt = 1'b0;
    #1;
    chk1("rstmid_waitrv_stall", memStall, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rstmid_stall_in_rst", memStall, 1'b0);
    @(posedge clk); #1;
    chk1("rstmid_wbValid", wbValid, 1'b0);
    @(negedge clk);
    rst = 1'b0; exValid = 1'b0; exMemRead = 1'b0; dRvalid = 1'b1; dRdata = 32'hCAFE_F00D;
    #1;
    chk1("rstmid_idle_stall", memStall, 1'b0);
    chk1("rstmid_idle_req", dReq, 1'b0);
    @(posedge clk); #1;
    chk1("rstmid_resp_ignored", wbValid, 1'b0);
    chk("rstmid_load", wbLoadData, 32'h0);
    @(negedge clk);
    dRvalid = 1'b0;
    idleCycle();

    nCmp++;
    if (sbq.size() != 0) begin
      nFail++;
      $display("FAIL sb_drain: got %0d pending retires expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
